// File: rtl/a25_wb_arb_pkg.sv
// ============================================================================
// Module   : a25_wb_arb_pkg
// Shared types, master indices and index helpers for the A25 Wishbone arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package a25_wb_arb_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int M_ICACHE    = 0;
  localparam int M_DCACHE    = 1;
  localparam int M_WBUF      = 2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWNED   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[M_DCACHE]) idx = 2'd1;
    if (oh[M_WBUF])   idx = 2'd2;
    return idx;
  endfunction

  // Index of the k-th master after 'last' in wrap-around order.
  function automatic logic [1:0] rr_index(input logic [1:0] last, input int k);
    return 2'((int'(last) + k) % NUM_MASTERS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/a25_wb_rr_pick.sv
// ============================================================================
// Module   : a25_wb_rr_pick
// Combinational round-robin picker: first requester after the last owner wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module a25_wb_rr_pick
  import a25_wb_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_requests,
  input  logic [1:0]             i_last_owner,
  output logic [NUM_MASTERS-1:0] o_grant
);

  // Walk from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    o_grant = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (i_requests[rr_index(i_last_owner, k)]) begin
        o_grant = '0;
        o_grant[rr_index(i_last_owner, k)] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/a25_wb_arbiter.sv
// ============================================================================
// Module   : a25_wb_arbiter
// Three-master Wishbone arbiter (I-cache, D-cache, write buffer), round-robin,
// bursts held atomic. Optional watchdog: define A25_WB_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module a25_wb_arbiter
  import a25_wb_arb_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [2:0]              i_m_cyc,
  input  logic [2:0]              i_m_stb,
  input  logic [2:0]              i_m_we,
  input  logic [3*(DATA_W/8)-1:0] i_m_sel,
  input  logic [3*32-1:0]         i_m_adr,
  input  logic [3*DATA_W-1:0]     i_m_dat,
  output logic [2:0]              o_m_ack,
  output logic [2:0]              o_m_err,
  output logic [DATA_W-1:0]       o_m_dat,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [DATA_W/8-1:0]     o_wb_sel,
  output logic [31:0]             o_wb_adr,
  output logic [DATA_W-1:0]       o_wb_dat,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic [DATA_W-1:0]       i_wb_dat,
  output logic [2:0]              o_grant
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_t              r_state;
  logic [NUM_MASTERS-1:0]  r_grant;
  logic [1:0]              r_last_owner;
  logic [NUM_MASTERS-1:0]  w_pick;
  logic                    w_owned;
  logic                    w_owner_cyc;
  logic                    w_owner_stb;
  logic                    w_owner_we;
  logic [SEL_W-1:0]        w_owner_sel;
  logic [31:0]             w_owner_adr;
  logic [DATA_W-1:0]       w_owner_dat;
  logic                    w_timeout;

  a25_wb_rr_pick u_pick (
    .i_requests   (i_m_cyc),
    .i_last_owner (r_last_owner),
    .o_grant      (w_pick)
  );

  assign w_owned = (r_state == ARB_OWNED);

  // r_grant is only non-zero while owned, so this AND-OR mux also zeroes the bus elsewhere.
  always_comb begin
    w_owner_cyc = 1'b0;
    w_owner_stb = 1'b0;
    w_owner_we  = 1'b0;
    w_owner_sel = '0;
    w_owner_adr = '0;
    w_owner_dat = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (r_grant[m]) begin
        w_owner_cyc = i_m_cyc[m];
        w_owner_stb = i_m_cyc[m] & i_m_stb[m];
        w_owner_we  = i_m_we[m];
        w_owner_sel = i_m_sel[m*SEL_W +: SEL_W];
        w_owner_adr = i_m_adr[m*32 +: 32];
        w_owner_dat = i_m_dat[m*DATA_W +: DATA_W];
      end
    end
  end

`ifdef A25_WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (!w_owned || i_wb_ack || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_owner_stb) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = w_owned & w_owner_stb & ~i_wb_ack &
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_owner <= 2'(M_WBUF);
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|i_m_cyc) begin
            r_state      <= ARB_OWNED;
            r_grant      <= w_pick;
            r_last_owner <= onehot_to_idx(w_pick);
          end
        end
        ARB_OWNED: begin
          if (!w_owner_cyc || w_timeout) begin
            r_state <= ARB_RELEASE;
            r_grant <= '0;
          end
        end
        ARB_RELEASE: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign o_grant  = r_grant;
  assign o_wb_cyc = w_owned;
  assign o_wb_stb = w_owner_stb;
  assign o_wb_we  = w_owner_we;
  assign o_wb_sel = w_owner_sel;
  assign o_wb_adr = w_owner_adr;
  assign o_wb_dat = w_owner_dat;
  assign o_m_ack  = {NUM_MASTERS{i_wb_ack}} & r_grant;
  assign o_m_err  = {NUM_MASTERS{i_wb_err | w_timeout}} & r_grant;
  assign o_m_dat  = i_wb_dat;

endmodule

`default_nettype wire

// File: tb/tb_a25_wb_arbiter.sv
// ============================================================================
// Module   : tb_a25_wb_arbiter
// Self-checking bench for a25_wb_arbiter (vector table, directed corners, random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_a25_wb_arbiter;

  localparam int DATA_W = 128;
  localparam int SEL_W  = DATA_W / 8;
  localparam int TO     = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [2:0]            m_cyc, m_stb, m_we;
  logic [3*SEL_W-1:0]    m_sel;
  logic [95:0]           m_adr;
  logic [3*DATA_W-1:0]   m_dat;
  logic [2:0]            m_ack, m_err, grant;
  logic [DATA_W-1:0]     m_dat_o, wb_dat_o, wb_dat_i;
  logic                  wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [SEL_W-1:0]      wb_sel;
  logic [31:0]           wb_adr;

  always #5 clk = ~clk;

  a25_wb_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_sel(m_sel),
    .i_m_adr(m_adr), .i_m_dat(m_dat),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_dat(m_dat_o),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat_i),
    .o_grant(grant)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, whether we're in the release gap, RR memory.
  int mo_owner = -1;
  bit mo_rel   = 1'b0;
  int mo_last  = 2;
  int mo_cnt   = 0;

  // Values seen at the most recent sample point.
  logic [2:0] s_ack, s_err, s_grant;
  logic       s_cyc;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rr_model(input logic [2:0] req);
    for (int k = 1; k <= 3; k++) begin
      int m;
      m = (mo_last + k) % 3;
      if (req[m]) return m;
    end
    return -1;
  endfunction

  function automatic bit exp_timeout();
    bit r;
    r = 1'b0;
`ifdef A25_WB_ARB_TIMEOUT_EN
    if (mo_owner >= 0)
      r = m_cyc[mo_owner] && m_stb[mo_owner] && !wb_ack && (mo_cnt == TO - 1);
`endif
    return r;
  endfunction

  task automatic check_model();
    bit         owned;
    int         o;
    bit         e_to;
    logic [2:0] e_grant;
    owned   = (mo_owner >= 0);
    o       = owned ? mo_owner : 0;
    e_to    = exp_timeout();
    e_grant = owned ? 3'(1 << o) : 3'b000;
    chk("grant",  grant,  e_grant);
    chk("wb_cyc", wb_cyc, owned);
    chk("wb_stb", wb_stb, owned && m_cyc[o] && m_stb[o]);
    chk("wb_we",  wb_we,  owned && m_we[o]);
    chk("wb_sel", wb_sel, owned ? m_sel[o*SEL_W +: SEL_W] : '0);
    chk("wb_adr", wb_adr, owned ? m_adr[o*32 +: 32] : '0);
    chk("wb_dat", wb_dat_o, owned ? m_dat[o*DATA_W +: DATA_W] : '0);
    chk("m_ack",  m_ack,  wb_ack ? e_grant : 3'b000);
    chk("m_err",  m_err,  (wb_err || e_to) ? e_grant : 3'b000);
    chk("m_dat",  m_dat_o, wb_dat_i);
  endtask

  task automatic model_advance();
    if (mo_owner >= 0) begin
      if (!m_cyc[mo_owner] || exp_timeout()) begin
        mo_owner = -1; mo_rel = 1'b1; mo_cnt = 0;
      end else if (wb_ack) mo_cnt = 0;
      else if (m_stb[mo_owner]) mo_cnt++;
    end else if (mo_rel) begin
      mo_rel = 1'b0;
    end else if (|m_cyc) begin
      mo_owner = rr_model(m_cyc);
      mo_last  = mo_owner;
    end
  endtask

  task automatic model_reset();
    mo_owner = -1; mo_rel = 1'b0; mo_last = 2; mo_cnt = 0;
  endtask

  // Entered at a falling edge with inputs already set.
  task automatic step();
    #1;
    s_ack = m_ack; s_err = m_err; s_grant = grant; s_cyc = wb_cyc;
    check_model();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
  endtask

  task automatic randomize_data();
    m_we  = 3'($urandom);
    m_sel = {$urandom, $urandom};
    m_adr = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++)
      m_dat[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
    wb_dat_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] cyc, stb;
    logic       ack, err;
    logic [2:0] e_grant;
    logic       e_cyc;
    logic [2:0] e_ack, e_err;
  } vec_t;

  vec_t vecs[13];
  int   acks0, acks1, idle, waited, err_cnt, first_err;
  bit   got_grant;

  initial begin
    clear_inputs();
    // Round-robin rotation 0,1,2,0 with drop+ack and error on the owner.
    vecs[0]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[1]  = '{3'b111, 3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 3'b000};
    vecs[2]  = '{3'b110, 3'b110, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000};
    vecs[3]  = '{3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[4]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[5]  = '{3'b101, 3'b000, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000};
    vecs[6]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[7]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[8]  = '{3'b111, 3'b100, 1'b0, 1'b1, 3'b100, 1'b1, 3'b000, 3'b100};
    vecs[9]  = '{3'b011, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000};
    vecs[10] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[11] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000};
    vecs[12] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000};

    do_reset();
    #1;
    chk("reset_grant", grant, 3'b000);
    chk("reset_wb_cyc", wb_cyc, 1'b0);
    chk("reset_m_ack", m_ack, 3'b000);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      randomize_data();
      m_cyc = vecs[i].cyc; m_stb = vecs[i].stb;
      wb_ack = vecs[i].ack; wb_err = vecs[i].err;
      step();
      chk($sformatf("vec%0d_grant", i), s_grant, vecs[i].e_grant);
      chk($sformatf("vec%0d_cyc", i),   s_cyc,   vecs[i].e_cyc);
      chk($sformatf("vec%0d_ack", i),   s_ack,   vecs[i].e_ack);
      chk($sformatf("vec%0d_err", i),   s_err,   vecs[i].e_err);
    end

    // Master 1 4-beat burst while master 0 waits.
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    step();
    acks0 = 0; acks1 = 0;
    for (int i = 0; i < 4; i++) begin
      m_cyc = 3'b011; m_stb = 3'b011; wb_ack = 1'b1;
      step();
      acks0 += int'(s_ack[0]); acks1 += int'(s_ack[1]);
    end
    m_cyc = 3'b001; m_stb = 3'b001; wb_ack = 1'b0;
    step();
    idle = 0; got_grant = 1'b0; waited = 0;
    while (!got_grant && waited < 10) begin
      step();
      waited++;
      if (s_grant == 3'b001) got_grant = 1'b1;
      else if (!s_cyc) idle++;
    end
    chk("burst_m1_acks", 32'(acks1), 32'd4);
    chk("burst_m0_acks", 32'(acks0), 32'd0);
    chk("burst_m0_granted", got_grant, 1'b1);
    chk("burst_idle_gap", 32'(idle), 32'd2);

    // Asynchronous reset mid-burst.
    do_reset();
    m_cyc = 3'b100; m_stb = 3'b100;
    step();
    wb_ack = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wb_cyc", wb_cyc, 1'b0);
    chk("async_rst_grant", grant, 3'b000);
    chk("async_rst_m_ack", m_ack, 3'b000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wb_ack = 1'b0;
    step();
    step();
    chk("rearb_grant", s_grant, 3'b100);

    // Strobe held with no ack for 100 cycles.
    do_reset();
    m_cyc = 3'b100; m_stb = 3'b100;
    step();
    err_cnt = 0; first_err = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (s_err != 3'b000) begin
        err_cnt++;
        if (first_err == 0) first_err = i;
      end
    end
`ifdef A25_WB_ARB_TIMEOUT_EN
    chk("timeout_first_err", 32'(first_err), 32'd8);
`else
    chk("no_timeout_errs", 32'(err_cnt), 32'd0);
    chk("no_timeout_cyc", s_cyc, 1'b1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int m = 0; m < 3; m++) begin
        if (m_cyc[m]) m_cyc[m] = ($urandom_range(5) != 0);
        else          m_cyc[m] = ($urandom_range(2) == 0);
      end
      m_stb  = 3'($urandom);
      wb_ack = ($urandom_range(1) == 0);
      wb_err = ($urandom_range(15) == 0);
      randomize_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/a25_wb_arbiter.md
A25_WB_ARBITER -- requirements
Module: a25_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 128: Wishbone data width in bits; SEL_W = DATA_W/8.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: watchdog limit in cycles, used only when the timeout feature is compiled in.
REQ-003 Clock is i_clk; reset is i_rst_n; the design uses one clock, and reset is asynchronous and active-low.
REQ-004 Ports, in this order:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_m_cyc  in  3  per-master cycle request; master 0 = I-cache, 1 = D-cache, 2 = write buffer
- i_m_stb  in  3  per-master strobe
- i_m_we  in  3  per-master write enable
- i_m_sel  in  3*SEL_W  per-master byte selects, packed with master 0 in the LSBs
- i_m_adr  in  3*32  per-master addresses, packed
- i_m_dat  in  3*DATA_W  per-master write data, packed
- o_m_ack  out  3  per-master acknowledge
- o_m_err  out  3  per-master error
- o_m_dat  out  DATA_W  read data, broadcast to all masters
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave-side controls
- o_wb_sel  out  SEL_W  slave-side byte selects
- o_wb_adr  out  32  slave-side address
- o_wb_dat  out  DATA_W  slave-side write data
- i_wb_ack, i_wb_err  in  1 each  slave responses
- i_wb_dat  in  DATA_W  slave read data
- o_grant  out  3  one-hot owner status

Function
REQ-005 The arbiter SHALL implement three states: ARB_IDLE, ARB_OWNED and ARB_RELEASE.
REQ-006 In ARB_IDLE, when any i_m_cyc bit is high, the arbiter SHALL register a one-hot grant and enter ARB_OWNED on the next edge.
- o_wb_cyc rises exactly 1 cycle after a request is seen in ARB_IDLE.
REQ-007 Grant selection SHALL be round-robin.
- Search order starts at last_owner+1 and wraps from 2 to 0.
- last_owner resets to 2, so master 0 wins the first arbitration.
REQ-008 In ARB_OWNED, o_wb_cyc SHALL be 1.
- o_wb_stb, we, sel, adr and dat SHALL be combinational muxes of the owner's inputs.
REQ-009 i_wb_ack and i_wb_err SHALL be routed only to the owner's o_m_ack/o_m_err bit.
- Non-owners SHALL see 0 on both.
- o_m_dat = i_wb_dat at all times.
REQ-010 Ownership SHALL persist while the owner's i_m_cyc is high, independent of other requests.
- This keeps the owner's 4-beat bursts atomic and uninterrupted.
REQ-011 When the owner's i_m_cyc drops, the arbiter SHALL go to ARB_RELEASE.
- ARB_RELEASE lasts exactly 1 cycle with all o_wb_* controls at 0, then returns to ARB_IDLE.
REQ-012 Minimum bus-idle gap between two owners SHALL be 2 cycles (ARB_RELEASE plus ARB_IDLE).
REQ-013 A simultaneous owner i_m_cyc drop and i_wb_ack SHALL still pass the ack to the owner in that cycle.
REQ-014 Outside ARB_OWNED, all o_wb_* controls, o_m_ack, o_m_err and o_grant SHALL be 0.
REQ-015 A master's i_m_stb without i_m_cyc SHALL be ignored.

Reset
REQ-016 Asserting i_rst_n low SHALL, asynchronously:
- force state to ARB_IDLE
- force o_grant to 0 and last_owner to 2
- drive all o_wb_* controls, o_m_ack and o_m_err to 0
- clear the timeout counter
REQ-017 Reset asserted mid-burst SHALL abort the transfer with no ack delivered; the arbiter re-arbitrates normally after release.

Configuration
REQ-018 Macro A25_WB_ARB_TIMEOUT_EN controls the watchdog.
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) increments each ARB_OWNED cycle with o_wb_stb=1 and i_wb_ack=0, and clears on ack.
- Defined, at TIMEOUT_CYCLES: a 1-cycle o_m_err pulse goes to the owner, o_wb_cyc drops, and the state enters ARB_RELEASE.
- Not defined: no counter exists, and ownership ends only via REQ-011.

Structure
REQ-019 Package a25_wb_arb_pkg SHALL hold:
- the state enum (ARB_IDLE, ARB_OWNED, ARB_RELEASE)
- NUM_MASTERS=3 and the master index constants M_ICACHE=0, M_DCACHE=1, M_WBUF=2
REQ-020 Sub-module a25_wb_rr_pick SHALL hold the combinational round-robin priority picker: requests[2:0] and last_owner in, one-hot grant out.

Verification
REQ-021 Reset, then i_m_cyc=3'b111 -> o_grant=001 after 1 cycle; successive owners follow the order 0, 1, 2, 0.
REQ-022 Master 1 runs a 4-beat burst with acks on consecutive cycles while master 0 requests -> master 1 receives all 4 acks and master 0 receives none; master 0 is granted 2 cycles after master 1's cyc drops.
REQ-023 Owner's cyc falls in the same cycle as i_wb_ack -> o_m_ack pulses 1 cycle, and the next cycle is ARB_RELEASE with o_wb_cyc=0.
REQ-024 i_wb_err during master 2's write -> only o_m_err[2] pulses; o_m_ack stays 000.
REQ-025 i_rst_n pulled low mid-burst, asynchronously -> o_wb_cyc=0 and o_grant=000 before the next clock edge.
REQ-026 With A25_WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, stb held without ack -> o_m_err pulses on the 8th unacked cycle, then ARB_RELEASE follows; without the macro, no error occurs after 100 cycles.
